// File: rtl/mem_access_pkg.sv
// Shared types for the memory-stage bus controller: FSM state encoding and
// access-size codes (access width is 2^size bytes).
package mem_access_pkg;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    BUSY = 2'd1,
    DONE = 2'd2
  } state_t;

  localparam logic [1:0] SZ_BYTE  = 2'd0;
  localparam logic [1:0] SZ_HALF  = 2'd1;
  localparam logic [1:0] SZ_WORD  = 2'd2;
  localparam logic [1:0] SZ_DWORD = 2'd3;

endpackage

// File: rtl/mem_lane_format.sv
// Combinational byte-lane formatter: store byte enables, lane-replicated store
// data, and little-endian extraction plus sign/zero extension of load data.
module mem_lane_format
  import mem_access_pkg::*;
#(
  parameter int DATA_W = 32,
  parameter int NB     = DATA_W / 8,
  parameter int OFF_W  = $clog2(NB)
) (
  input  logic [1:0]        i_size,
  input  logic              i_sign,
  input  logic [OFF_W-1:0]  i_off,
  input  logic [DATA_W-1:0] i_wdata,
  input  logic [DATA_W-1:0] i_rdata,
  output logic [NB-1:0]     o_be,
  output logic [DATA_W-1:0] o_wdata,
  output logic [DATA_W-1:0] o_rdata
);

  logic [DATA_W-1:0]        w_shifted;
  logic [DATA_W-1:0]        w_left;
  logic signed [DATA_W-1:0] w_sra;
  logic [6:0]               w_pad;

  assign w_shifted = i_rdata >> {i_off, 3'b000};

  always_comb begin
    o_be    = '1;
    o_wdata = i_wdata;
    w_pad   = 7'd0;
    case (i_size)
      SZ_BYTE: begin
        o_be    = NB'(1) << i_off;
        o_wdata = {NB{i_wdata[7:0]}};
        w_pad   = 7'(DATA_W - 8);
      end
      SZ_HALF: begin
        o_be    = NB'(3) << i_off;
        o_wdata = {(NB/2){i_wdata[15:0]}};
        w_pad   = 7'(DATA_W - 16);
      end
      SZ_WORD: begin
        o_be    = NB'(15) << i_off;
        o_wdata = {(NB/4){i_wdata[31:0]}};
        w_pad   = 7'(DATA_W - 32);
      end
      default: begin
        o_be    = '1;
        o_wdata = i_wdata;
        w_pad   = 7'd0;
      end
    endcase
  end

  // Push the field to the top, then shift back down arithmetically or logically.
  always_comb begin
    w_left  = w_shifted << w_pad;
    w_sra   = $signed(w_left) >>> w_pad;
    o_rdata = i_sign ? DATA_W'(w_sra) : (w_left >> w_pad);
  end

endmodule

// File: rtl/mem_access_unit.sv
// MEM-stage bus controller: holds one load/store on the bus until bus_ready,
// stalling the pipeline meanwhile. Optional bus timeout under MEM_TIMEOUT_EN.
module mem_access_unit
  import mem_access_pkg::*;
#(
  parameter int DATA_W         = 32,
  parameter int ADDR_W         = 32,
  parameter int TIMEOUT_CYCLES = 255
) (
  input  logic                clk,
  input  logic                rst,
  input  logic                req_valid,
  input  logic                req_write,
  input  logic [1:0]          req_size,
  input  logic                req_sign,
  input  logic [ADDR_W-1:0]   req_addr,
  input  logic [DATA_W-1:0]   req_wdata,
  output logic                mem_stall,
  output logic                rsp_valid,
  output logic [DATA_W-1:0]   rsp_rdata,
  output logic                misaligned,
  output logic                timeout_err,
  output logic                bus_req,
  output logic                bus_we,
  output logic [ADDR_W-1:0]   bus_addr,
  output logic [DATA_W-1:0]   bus_wdata,
  output logic [DATA_W/8-1:0] bus_be,
  input  logic [DATA_W-1:0]   bus_rdata,
  input  logic                bus_ready,
  output state_t              dbg_state
);

  localparam int NB    = DATA_W / 8;
  localparam int OFF_W = $clog2(NB);

  if (!(DATA_W == 32 || DATA_W == 64) || TIMEOUT_CYCLES < 1) begin : g_param_check
    $error("mem_access_unit: DATA_W must be 32 or 64 and TIMEOUT_CYCLES >= 1");
  end

  state_t              r_state;
  logic [1:0]          r_size;
  logic                r_sign;
  logic [OFF_W-1:0]    r_off;
  logic                r_write;
  logic                r_rsp_valid;
  logic [DATA_W-1:0]   r_rsp_rdata;
  logic                r_bus_req;
  logic                r_bus_we;
  logic [ADDR_W-1:0]   r_bus_addr;
  logic [DATA_W-1:0]   r_bus_wdata;
  logic [NB-1:0]       r_bus_be;

  logic [OFF_W-1:0]    w_off;
  logic [OFF_W-1:0]    w_align_mask;
  logic                w_legal;
  logic                w_idle;
  logic                w_accept;
  logic [1:0]          w_fmt_size;
  logic                w_fmt_sign;
  logic [OFF_W-1:0]    w_fmt_off;
  logic [NB-1:0]       w_be;
  logic [DATA_W-1:0]   w_wrep;
  logic [DATA_W-1:0]   w_rext;

  assign w_off        = req_addr[OFF_W-1:0];
  assign w_align_mask = ~({OFF_W{1'b1}} << req_size);
  assign w_legal      = (req_size <= 2'(OFF_W)) && ((w_off & w_align_mask) == '0);
  assign w_idle       = (r_state == IDLE);
  assign w_accept     = w_idle && req_valid && w_legal;

  // In IDLE the formatter sees the live request; afterwards the latched one.
  assign w_fmt_size = w_idle ? req_size : r_size;
  assign w_fmt_sign = w_idle ? req_sign : r_sign;
  assign w_fmt_off  = w_idle ? w_off    : r_off;

  mem_lane_format #(.DATA_W(DATA_W)) u_fmt (
    .i_size  (w_fmt_size),
    .i_sign  (w_fmt_sign),
    .i_off   (w_fmt_off),
    .i_wdata (req_wdata),
    .i_rdata (bus_rdata),
    .o_be    (w_be),
    .o_wdata (w_wrep),
    .o_rdata (w_rext)
  );

`ifdef MEM_TIMEOUT_EN
  localparam int CNT_W = $clog2(TIMEOUT_CYCLES + 1);
  logic [CNT_W-1:0] r_tcnt;
  logic             r_terr;
  assign timeout_err = r_terr;
`else
  assign timeout_err = 1'b0;
`endif

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_state     <= IDLE;
      r_size      <= SZ_BYTE;
      r_sign      <= 1'b0;
      r_off       <= '0;
      r_write     <= 1'b0;
      r_rsp_valid <= 1'b0;
      r_rsp_rdata <= '0;
      r_bus_req   <= 1'b0;
      r_bus_we    <= 1'b0;
      r_bus_addr  <= '0;
      r_bus_wdata <= '0;
      r_bus_be    <= '0;
`ifdef MEM_TIMEOUT_EN
      r_tcnt      <= '0;
      r_terr      <= 1'b0;
`endif
    end else begin
      case (r_state)
        IDLE: begin
          r_rsp_valid <= 1'b0;
          if (w_accept) begin
            r_size      <= req_size;
            r_sign      <= req_sign;
            r_off       <= w_off;
            r_write     <= req_write;
            r_bus_req   <= 1'b1;
            r_bus_we    <= req_write;
            r_bus_addr  <= req_addr & ~ADDR_W'(NB - 1);
            r_bus_wdata <= w_wrep;
            r_bus_be    <= w_be;
            r_state     <= BUSY;
`ifdef MEM_TIMEOUT_EN
            r_tcnt      <= '0;
`endif
          end
        end
        BUSY: begin
          if (bus_ready) begin
            r_rsp_rdata <= r_write ? '0 : w_rext;
            r_rsp_valid <= 1'b1;
            r_bus_req   <= 1'b0;
            r_bus_we    <= 1'b0;
            r_state     <= DONE;
`ifdef MEM_TIMEOUT_EN
          end else if (r_tcnt == CNT_W'(TIMEOUT_CYCLES - 1)) begin
            r_rsp_rdata <= '0;
            r_rsp_valid <= 1'b1;
            r_terr      <= 1'b1;
            r_bus_req   <= 1'b0;
            r_bus_we    <= 1'b0;
            r_state     <= DONE;
          end else begin
            r_tcnt      <= r_tcnt + 1'b1;
`endif
          end
        end
        DONE: begin
          r_rsp_valid <= 1'b0;
`ifdef MEM_TIMEOUT_EN
          r_terr      <= 1'b0;
`endif
          r_state     <= IDLE;
        end
        default: r_state <= IDLE;
      endcase
    end
  end

  // Gated by rst so the stall and misalign pulses vanish the moment reset asserts.
  assign mem_stall  = rst & ((r_state == BUSY) | w_accept);
  assign misaligned = rst & w_idle & req_valid & ~w_legal;
  assign rsp_valid  = r_rsp_valid;
  assign rsp_rdata  = r_rsp_rdata;
  assign bus_req    = r_bus_req;
  assign bus_we     = r_bus_we;
  assign bus_addr   = r_bus_addr;
  assign bus_wdata  = r_bus_wdata;
  assign bus_be     = r_bus_be;
  assign dbg_state  = r_state;

endmodule
